// File: rtl/drawbridge_sequencer.sv
// Drawbridge sequencer: counts cars on the deck, warns road traffic, closes the barrier,
// waits for the deck to drain, then raises the span against its limit switches, holds it
// open while boats pass, lowers it and reopens the road. Motor travel that overruns a
// time limit, or both limit switches reading high, latches a fault that only reset clears.
module drawbridge_sequencer #(
  parameter int unsigned CNT_W        = 4,
  parameter int unsigned ALERT_CYCLES = 8,
  parameter int unsigned MOVE_TIMEOUT = 64,
  parameter int unsigned CLEAR_CYCLES = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_carIn,
  input  logic             i_carOut,
  input  logic             i_boatClose,
  input  logic             i_boatHere,
  input  logic             i_bridgeUp,
  input  logic             i_bridgeDown,
  output logic             o_carBarrier,
  output logic             o_alert,
  output logic             o_motorUp,
  output logic             o_motorDown,
  output logic             o_bridge_s,
  output logic             o_fault,
  output logic [CNT_W-1:0] o_carCount,
  output logic [2:0]       o_state
);

  // One timer serves both the warning period and motor travel supervision.
  localparam int unsigned TimerMax = (ALERT_CYCLES > MOVE_TIMEOUT) ? ALERT_CYCLES : MOVE_TIMEOUT;
  localparam int unsigned TimerW   = $clog2(TimerMax + 1);
  localparam int unsigned ClearW   = $clog2(CLEAR_CYCLES + 1);

  localparam logic [TimerW-1:0] AlertLast = TimerW'(ALERT_CYCLES - 1);
  localparam logic [TimerW-1:0] MoveLast  = TimerW'(MOVE_TIMEOUT - 1);
  localparam logic [ClearW-1:0] ClearLast = ClearW'(CLEAR_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CntMax    = '1;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StAlert = 3'd1,
    StDrain = 3'd2,
    StRaise = 3'd3,
    StOpen  = 3'd4,
    StLower = 3'd5,
    StFault = 3'd7
  } state_e;

  state_e            r_state;
  logic [TimerW-1:0] r_timer;
  logic [ClearW-1:0] r_clear;
  logic [CNT_W-1:0]  r_carCount;
  logic              w_boat;

  assign w_boat = i_boatClose | i_boatHere;

  // Car-on-deck counter: saturates at full scale, never underflows, runs in every state.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_carCount <= '0;
    end else begin
      case ({i_carIn, i_carOut})
        2'b10:   if (r_carCount != CntMax) r_carCount <= r_carCount + CNT_W'(1);
        2'b01:   if (r_carCount != '0)     r_carCount <= r_carCount - CNT_W'(1);
        default: r_carCount <= r_carCount;
      endcase
    end
  end

  // Sequencer state, travel/warning timer and boat-free counter.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= StIdle;
      r_timer <= '0;
      r_clear <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_boat) begin
            r_state <= StAlert;
            r_timer <= '0;
          end
        end
        StAlert: begin
          // A boat leaving mid-warning does not abort; the span cycle always completes.
          if (r_timer == AlertLast) begin
            r_state <= StDrain;
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + TimerW'(1);
          end
        end
        StDrain: begin
          if (r_carCount == '0) begin
            r_state <= StRaise;
            r_timer <= '0;
          end
        end
        StRaise: begin
          if (i_bridgeUp && i_bridgeDown) begin
            r_state <= StFault;
          end else if (i_bridgeUp) begin
            r_state <= StOpen;
            r_clear <= '0;
          end else if (r_timer == MoveLast) begin
            r_state <= StFault;
          end else begin
            r_timer <= r_timer + TimerW'(1);
          end
        end
        StOpen: begin
          if (w_boat) begin
            r_clear <= '0;
          end else if (r_clear == ClearLast) begin
            r_state <= StLower;
            r_timer <= '0;
          end else begin
            r_clear <= r_clear + ClearW'(1);
          end
        end
        StLower: begin
          // A returning boat reverses the span even if the lower switch just closed.
          if (i_bridgeUp && i_bridgeDown) begin
            r_state <= StFault;
          end else if (w_boat) begin
            r_state <= StRaise;
            r_timer <= '0;
          end else if (i_bridgeDown) begin
            r_state <= StIdle;
          end else if (r_timer == MoveLast) begin
            r_state <= StFault;
          end else begin
            r_timer <= r_timer + TimerW'(1);
          end
        end
        StFault: r_state <= StFault;
        default: r_state <= StFault;
      endcase
    end
  end

  // Moore output decode from the registered state only.
  always_comb begin
    o_carBarrier = 1'b0;
    o_alert      = 1'b0;
    o_motorUp    = 1'b0;
    o_motorDown  = 1'b0;
    o_bridge_s   = 1'b0;
    o_fault      = 1'b0;
    case (r_state)
      StIdle: ;
      StAlert: o_alert = 1'b1;
      StDrain: begin
        o_carBarrier = 1'b1;
        o_alert      = 1'b1;
      end
      StRaise: begin
        o_carBarrier = 1'b1;
        o_alert      = 1'b1;
        o_motorUp    = 1'b1;
      end
      StOpen: begin
        o_carBarrier = 1'b1;
        o_alert      = 1'b1;
        o_bridge_s   = 1'b1;
      end
      StLower: begin
        o_carBarrier = 1'b1;
        o_alert      = 1'b1;
        o_motorDown  = 1'b1;
      end
      default: begin
        o_carBarrier = 1'b1;
        o_alert      = 1'b1;
        o_fault      = 1'b1;
      end
    endcase
  end

  assign o_carCount = r_carCount;
  assign o_state    = r_state;

endmodule

// File: tb/tb_drawbridge_sequencer.sv
// Directed self-checking bench for drawbridge_sequencer.
module tb_drawbridge_sequencer;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_carIn = 1'b0;
  logic       i_carOut = 1'b0;
  logic       i_boatClose = 1'b0;
  logic       i_boatHere = 1'b0;
  logic       i_bridgeUp = 1'b0;
  logic       i_bridgeDown = 1'b0;
  logic       o_carBarrier;
  logic       o_alert;
  logic       o_motorUp;
  logic       o_motorDown;
  logic       o_bridge_s;
  logic       o_fault;
  logic [3:0] o_carCount;
  logic [2:0] o_state;
  logic [5:0] w_outs;

  int n_checks = 0;
  int n_errors = 0;

  // {barrier, alert, up, down, bridge_s, fault}
  localparam logic [5:0] OutIdle  = 6'b000000;
  localparam logic [5:0] OutAlert = 6'b010000;
  localparam logic [5:0] OutDrain = 6'b110000;
  localparam logic [5:0] OutRaise = 6'b111000;
  localparam logic [5:0] OutOpen  = 6'b110010;
  localparam logic [5:0] OutLower = 6'b110100;
  localparam logic [5:0] OutFault = 6'b110001;

  assign w_outs = {o_carBarrier, o_alert, o_motorUp, o_motorDown, o_bridge_s, o_fault};

  drawbridge_sequencer #(
    .CNT_W       (4),
    .ALERT_CYCLES(8),
    .MOVE_TIMEOUT(64),
    .CLEAR_CYCLES(4)
  ) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_carIn     (i_carIn),
    .i_carOut    (i_carOut),
    .i_boatClose (i_boatClose),
    .i_boatHere  (i_boatHere),
    .i_bridgeUp  (i_bridgeUp),
    .i_bridgeDown(i_bridgeDown),
    .o_carBarrier(o_carBarrier),
    .o_alert     (o_alert),
    .o_motorUp   (o_motorUp),
    .o_motorDown (o_motorDown),
    .o_bridge_s  (o_bridge_s),
    .o_fault     (o_fault),
    .o_carCount  (o_carCount),
    .o_state     (o_state)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_carIn      = 1'b0;
    i_carOut     = 1'b0;
    i_boatClose  = 1'b0;
    i_boatHere   = 1'b0;
    i_bridgeUp   = 1'b0;
    i_bridgeDown = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    i_reset = 1'b0;
    step();
    step();
    i_reset = 1'b1;
  endtask

  task automatic pulse_in();
    i_carIn = 1'b1;
    step();
    i_carIn = 1'b0;
  endtask

  task automatic pulse_out();
    i_carOut = 1'b1;
    step();
    i_carOut = 1'b0;
  endtask

  // Drive from reset to the first RAISE cycle (boat at cycle 0, RAISE at cycle 10).
  task automatic go_raise();
    do_reset();
    i_boatClose = 1'b1;
    repeat (10) step();
  endtask

  task automatic go_lower();
    go_raise();
    i_bridgeUp = 1'b1;
    step();
    i_bridgeUp  = 1'b0;
    i_boatClose = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (o_state !== 3'd0) begin
      n_errors++; $display("FAIL reset_state: got %0d expected 0", o_state);
    end
    n_checks++;
    if (w_outs !== OutIdle) begin
      n_errors++; $display("FAIL reset_outputs: got %b expected %b", w_outs, OutIdle);
    end
    n_checks++;
    if (o_carCount !== 4'd0) begin
      n_errors++; $display("FAIL reset_count: got %0d expected 0", o_carCount);
    end
  endtask

  task automatic test_nominal();
    do_reset();
    i_boatClose = 1'b1;             // cycle 0
    step();                         // cycle 1
    n_checks++;
    if (o_state !== 3'd1 || w_outs !== OutAlert) begin
      n_errors++; $display("FAIL nom_alert_c1: got st=%0d out=%b expected st=1 out=%b", o_state, w_outs, OutAlert);
    end
    repeat (7) step();              // cycle 8
    n_checks++;
    if (o_state !== 3'd1) begin
      n_errors++; $display("FAIL nom_alert_c8: got %0d expected 1", o_state);
    end
    step();                         // cycle 9
    n_checks++;
    if (o_state !== 3'd2 || w_outs !== OutDrain) begin
      n_errors++; $display("FAIL nom_drain_c9: got st=%0d out=%b expected st=2 out=%b", o_state, w_outs, OutDrain);
    end
    step();                         // cycle 10
    n_checks++;
    if (o_state !== 3'd3 || w_outs !== OutRaise) begin
      n_errors++; $display("FAIL nom_raise_c10: got st=%0d out=%b expected st=3 out=%b", o_state, w_outs, OutRaise);
    end
    repeat (5) step();              // cycle 15
    i_bridgeUp = 1'b1;
    step();                         // cycle 16
    n_checks++;
    if (o_state !== 3'd4 || w_outs !== OutOpen) begin
      n_errors++; $display("FAIL nom_open_c16: got st=%0d out=%b expected st=4 out=%b", o_state, w_outs, OutOpen);
    end
    i_bridgeUp = 1'b0;
    repeat (4) step();              // cycle 20
    i_boatClose = 1'b0;
    repeat (3) step();              // cycle 23
    n_checks++;
    if (o_state !== 3'd4) begin
      n_errors++; $display("FAIL nom_open_c23: got %0d expected 4", o_state);
    end
    step();                         // cycle 24
    n_checks++;
    if (o_state !== 3'd5 || w_outs !== OutLower) begin
      n_errors++; $display("FAIL nom_lower_c24: got st=%0d out=%b expected st=5 out=%b", o_state, w_outs, OutLower);
    end
    repeat (6) step();              // cycle 30
    i_bridgeDown = 1'b1;
    step();                         // cycle 31
    n_checks++;
    if (o_state !== 3'd0 || w_outs !== OutIdle) begin
      n_errors++; $display("FAIL nom_idle_c31: got st=%0d out=%b expected st=0 out=%b", o_state, w_outs, OutIdle);
    end
    i_bridgeDown = 1'b0;
  endtask

  task automatic test_drain();
    do_reset();
    repeat (3) pulse_in();
    n_checks++;
    if (o_carCount !== 4'd3) begin
      n_errors++; $display("FAIL drain_count3: got %0d expected 3", o_carCount);
    end
    i_boatHere = 1'b1;
    repeat (9) step();
    repeat (3) step();
    n_checks++;
    if (o_state !== 3'd2) begin
      n_errors++; $display("FAIL drain_hold: got %0d expected 2", o_state);
    end
    i_boatHere = 1'b0;
    repeat (3) pulse_out();
    n_checks++;
    if (o_carCount !== 4'd0 || o_state !== 3'd2) begin
      n_errors++; $display("FAIL drain_empty: got cnt=%0d st=%0d expected cnt=0 st=2", o_carCount, o_state);
    end
    step();
    n_checks++;
    if (o_state !== 3'd3) begin
      n_errors++; $display("FAIL drain_to_raise: got %0d expected 3", o_state);
    end
  endtask

  task automatic test_counter_edges();
    do_reset();
    pulse_in();
    i_carIn  = 1'b1;
    i_carOut = 1'b1;
    step();
    clear_inputs();
    n_checks++;
    if (o_carCount !== 4'd1) begin
      n_errors++; $display("FAIL cnt_both: got %0d expected 1", o_carCount);
    end
    i_carIn = 1'b1;
    repeat (20) step();
    i_carIn = 1'b0;
    n_checks++;
    if (o_carCount !== 4'd15) begin
      n_errors++; $display("FAIL cnt_saturate: got %0d expected 15", o_carCount);
    end
    pulse_out();
    n_checks++;
    if (o_carCount !== 4'd14) begin
      n_errors++; $display("FAIL cnt_dec: got %0d expected 14", o_carCount);
    end
    do_reset();
    pulse_out();
    n_checks++;
    if (o_carCount !== 4'd0) begin
      n_errors++; $display("FAIL cnt_underflow: got %0d expected 0", o_carCount);
    end
  endtask

  task automatic test_boat_return();
    go_lower();
    n_checks++;
    if (o_state !== 3'd5 || o_motorDown !== 1'b1) begin
      n_errors++; $display("FAIL ret_lower: got st=%0d dn=%b expected st=5 dn=1", o_state, o_motorDown);
    end
    i_boatHere   = 1'b1;
    i_bridgeDown = 1'b1;
    step();
    i_bridgeDown = 1'b0;
    n_checks++;
    if (o_state !== 3'd3 || w_outs !== OutRaise) begin
      n_errors++; $display("FAIL ret_raise: got st=%0d out=%b expected st=3 out=%b", o_state, w_outs, OutRaise);
    end
    // Timer restarted on reversal: 64 RAISE cycles before the timeout.
    repeat (63) step();
    n_checks++;
    if (o_state !== 3'd3) begin
      n_errors++; $display("FAIL ret_timer_restart: got %0d expected 3", o_state);
    end
    step();
    n_checks++;
    if (o_state !== 3'd7) begin
      n_errors++; $display("FAIL ret_timeout: got %0d expected 7", o_state);
    end
  endtask

  task automatic test_timeout();
    logic [3:0] pats [4];
    pats[0] = 4'b1111;
    pats[1] = 4'b0010;
    pats[2] = 4'b0001;
    pats[3] = 4'b1100;
    go_raise();
    repeat (63) step();
    n_checks++;
    if (o_state !== 3'd3) begin
      n_errors++; $display("FAIL to_still_raise: got %0d expected 3", o_state);
    end
    step();
    n_checks++;
    if (o_state !== 3'd7 || w_outs !== OutFault) begin
      n_errors++; $display("FAIL to_fault: got st=%0d out=%b expected st=7 out=%b", o_state, w_outs, OutFault);
    end
    for (int i = 0; i < 4; i++) begin
      {i_boatClose, i_boatHere, i_bridgeUp, i_bridgeDown} = pats[i];
      step();
      n_checks++;
      if (o_state !== 3'd7 || w_outs !== OutFault) begin
        n_errors++; $display("FAIL to_fault_hold%0d: got st=%0d out=%b expected st=7 out=%b", i, o_state, w_outs, OutFault);
      end
    end
    clear_inputs();
    pulse_in();
    n_checks++;
    if (o_carCount !== 4'd1) begin
      n_errors++; $display("FAIL to_fault_count: got %0d expected 1", o_carCount);
    end
  endtask

  task automatic test_switch_fault();
    go_lower();
    i_bridgeUp   = 1'b1;
    i_bridgeDown = 1'b1;
    step();
    n_checks++;
    if (o_state !== 3'd7 || o_fault !== 1'b1) begin
      n_errors++; $display("FAIL sw_lower: got st=%0d fault=%b expected st=7 fault=1", o_state, o_fault);
    end
    go_raise();
    i_bridgeUp   = 1'b1;
    i_bridgeDown = 1'b1;
    step();
    n_checks++;
    if (o_state !== 3'd7) begin
      n_errors++; $display("FAIL sw_raise: got %0d expected 7", o_state);
    end
  endtask

  task automatic test_async_reset();
    go_raise();
    repeat (2) pulse_in();          // violators counted, sequence unaffected
    n_checks++;
    if (o_state !== 3'd3 || o_carCount !== 4'd2) begin
      n_errors++; $display("FAIL ar_violator: got st=%0d cnt=%0d expected st=3 cnt=2", o_state, o_carCount);
    end
    #2;
    i_reset = 1'b0;
    #1;
    n_checks++;
    if (o_motorUp !== 1'b0 || o_carCount !== 4'd0 || o_state !== 3'd0 || w_outs !== OutIdle) begin
      n_errors++; $display("FAIL ar_async: got st=%0d cnt=%0d out=%b expected st=0 cnt=0 out=%b", o_state, o_carCount, w_outs, OutIdle);
    end
    clear_inputs();
    step();
    i_reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_nominal();
    test_drain();
    test_counter_edges();
    test_boat_return();
    test_timeout();
    test_switch_fault();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/drawbridge_sequencer.md
Name: drawbridge_sequencer

Overview:
Top-level sequencer for the drawbridge. It tracks cars on the deck, warns road traffic, closes the barrier, and drains the deck. It then drives the lift motor against limit switches, holds the span open while boats pass, lowers it and reopens the road. Motor travel that exceeds a time limit, or inconsistent limit switches, latch a fault.

Parameters:
CNT_W, 4, width of the car-on-deck counter
ALERT_CYCLES, 8, cycles of warning before the barrier closes (>=1)
MOVE_TIMEOUT, 64, maximum cycles of motor travel before fault (>=2)
CLEAR_CYCLES, 4, consecutive boat-free cycles required before lowering (>=1)

Ports:
i_clk  in  1  system clock, rising edge
i_reset  in  1  reset; asynchronous, active-low
i_carIn  in  1  one-cycle pulse per car entering deck
i_carOut  in  1  one-cycle pulse per car leaving deck
i_boatClose  in  1  boat approaching (level)
i_boatHere  in  1  boat at bridge (level)
i_bridgeUp  in  1  upper limit switch (span fully raised)
i_bridgeDown  in  1  lower limit switch (span fully lowered)
o_carBarrier  out  1  1 = road barrier closed
o_alert  out  1  1 = warning lights on
o_motorUp  out  1  raise motor drive
o_motorDown  out  1  lower motor drive
o_bridge_s  out  1  1 = span raised/open to boats
o_fault  out  1  latched fault
o_carCount  out  CNT_W  cars currently on deck
o_state  out  3  current state encoding

Behaviour:
- Reset (i_reset=0, async): state IDLE, car count 0, all timers 0, all 1-bit outputs 0, o_state=0.
- Outputs are decoded combinationally from the registered state only (Moore). o_motorUp and o_motorDown are never both 1.
- Car counter, in every state including FAULT:
  - carIn only: +1, saturating at 2^CNT_W-1.
  - carOut only: -1, held at 0 (no underflow).
  - Both or neither: unchanged.
  - o_carCount is the registered count.
- boat = i_boatClose | i_boatHere.
- States, with encoding, outputs (barrier/alert/up/down/bridge_s) and transitions:
  - IDLE 0 (0/0/0/0/0): boat=1 -> ALERT, timer cleared.
  - ALERT 1 (0/1/0/0/0): timer increments each cycle. After exactly ALERT_CYCLES cycles in ALERT -> DRAIN. A boat dropping during ALERT does not abort the sequence.
  - DRAIN 2 (1/1/0/0/0): count==0 -> RAISE, timer cleared. The check uses the registered count; a car leaving this cycle is seen next cycle. No timeout.
  - RAISE 3 (1/1/1/0/0):
    - i_bridgeUp & i_bridgeDown -> FAULT.
    - else i_bridgeUp -> OPEN, clear counter cleared.
    - else timer == MOVE_TIMEOUT-1 -> FAULT.
  - OPEN 4 (1/1/0/0/1):
    - Clear counter increments while boat=0 and resets to 0 when boat=1.
    - Reaching CLEAR_CYCLES -> LOWER, timer cleared.
  - LOWER 5 (1/1/0/1/0):
    - Both limits high -> FAULT.
    - else boat=1 -> RAISE, timer cleared (reversal has priority over i_bridgeDown).
    - else i_bridgeDown -> IDLE.
    - else timer == MOVE_TIMEOUT-1 -> FAULT.
  - FAULT 7 (1/1/0/0/0), o_fault=1: motors off. Exit only via reset.
  - Encoding 6 is unused; an illegal state goes to FAULT.
- o_bridge_s is 1 only in OPEN.
- The barrier reopens in the same cycle the state reaches IDLE.
- Cars entering while the barrier is closed (violators) are still counted, but once in RAISE/OPEN/LOWER they do not alter the sequence.
- Mid-operation reset: all outputs, including motors, drop to 0 immediately and asynchronously.

Test Plan:
- Nominal cycle, no cars: boatClose=1 at cycle 0 -> ALERT cycles 1-8, DRAIN at 9, RAISE at 10; i_bridgeUp at cycle 15 -> OPEN at 16 with o_bridge_s=1; boats drop at 20 -> LOWER at 24; i_bridgeDown at 30 -> IDLE at 31 with barrier=0.
- Drain: three carIn pulses, then boat -> the sequence holds in DRAIN until three carOut pulses; RAISE follows the cycle after o_carCount reads 0.
- Counter edges: carIn and carOut in the same cycle -> count unchanged; 20 carIn pulses with CNT_W=4 -> count saturates at 15; carOut at 0 -> count stays 0.
- Boat returns during LOWER: boatHere=1 while o_motorDown=1 -> RAISE next cycle with o_motorUp=1 and the timer restarted; simultaneous i_bridgeDown is ignored.
- Timeout and switch fault: in RAISE, no i_bridgeUp for 64 cycles -> FAULT, o_fault=1, motors 0, state stays 7 under any input. Separately, both limits high in LOWER -> FAULT next cycle.
- Async reset: assert i_reset=0 mid-RAISE between clock edges -> o_motorUp=0 and o_carCount=0 without any clock edge.
